// File: rtl/bcrypt_axis8_out_arbiter_if.sv
// bcrypt_axis8_out_arbiter_if: NUM_SRC-lane AXIS8 source bundle plus the merged AXIS8 host stream.
// master is the arbiter's view; slave is the surrounding sources and sink.
interface bcrypt_axis8_out_arbiter_if #(
    parameter int NUM_SRC = 4,
    parameter int SRC_W   = $clog2(NUM_SRC)
);
    logic [NUM_SRC*8-1:0] s_tdata;
    logic [NUM_SRC-1:0]   s_tvalid;
    logic [NUM_SRC-1:0]   s_tready;
    logic [NUM_SRC-1:0]   s_tlast;
    logic [7:0]           m_tdata;
    logic                 m_tvalid;
    logic                 m_tready;
    logic                 m_tlast;
    logic [SRC_W-1:0]     m_tid;
    modport master (
        input  s_tdata, s_tvalid, s_tlast, m_tready,
        output s_tready, m_tdata, m_tvalid, m_tlast, m_tid
    );
    modport slave (
        output s_tdata, s_tvalid, s_tlast, m_tready,
        input  s_tready, m_tdata, m_tvalid, m_tlast, m_tid
    );
endinterface

// File: rtl/bcrypt_axis8_out_arbiter.sv
// bcrypt_axis8_out_arbiter: packet-atomic round-robin merge of NUM_SRC AXIS8 sources onto one
// host stream, with source tagging and forced termination of over-long packets.
module bcrypt_axis8_out_arbiter #(
    parameter int NUM_SRC       = 4,
    parameter int MAX_PKT_BYTES = 1024,
    parameter int SRC_W         = $clog2(NUM_SRC)
) (
    input  logic        CLK,
    input  logic        RSTN,
    bcrypt_axis8_out_arbiter_if.master bus,
    input  logic        enable,
    output logic        busy,
    output logic        err_len,
    output logic [31:0] pkt_count
);
    localparam int CNT_W = $clog2(MAX_PKT_BYTES + 1);
    typedef enum logic [1:0] {IDLE, XFER, DRAIN} state_t;
    state_t state_q, state_d;
    logic [SRC_W-1:0] grant_q, grant_d, last_grant_q, pick;
    logic [CNT_W-1:0] cnt_q;
    logic [NUM_SRC-1:0] ready;
    logic acc, xfer_acc, s_last, at_max;
    // Descending scan so the nearest requester after last_grant is the final (winning) write
    always_comb begin
        pick = last_grant_q;
        for (int k = NUM_SRC; k >= 1; k--)
            if (bus.s_tvalid[(int'(last_grant_q) + k) % NUM_SRC])
                pick = SRC_W'((int'(last_grant_q) + k) % NUM_SRC);
    end
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        ready = '0;
        ready[grant_q] = state_q == DRAIN || (state_q == XFER && (!bus.m_tvalid || bus.m_tready));
        acc = bus.s_tvalid[grant_q] && ready[grant_q];
        xfer_acc = acc && state_q == XFER;
        s_last = bus.s_tlast[grant_q];
        at_max = cnt_q == CNT_W'(MAX_PKT_BYTES - 1);
        if (state_q == IDLE && enable && |bus.s_tvalid) begin
            grant_d = pick;
            state_d = XFER;
        end
        if (xfer_acc)
            state_d = s_last ? IDLE : at_max ? DRAIN : XFER;
        if (state_q == DRAIN && acc && s_last)
            state_d = IDLE;
    end
    assign bus.s_tready = ready;
    assign busy = state_q != IDLE || bus.m_tvalid;
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_q <= IDLE;
            grant_q <= '0;
            last_grant_q <= SRC_W'(NUM_SRC - 1);
            cnt_q <= '0;
            bus.m_tdata <= '0;
            bus.m_tvalid <= 1'b0;
            bus.m_tlast <= 1'b0;
            bus.m_tid <= '0;
            err_len <= 1'b0;
            pkt_count <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            if (xfer_acc)
                cnt_q <= (s_last || at_max) ? '0 : cnt_q + 1'b1;
            if (state_q != IDLE && state_d == IDLE)
                last_grant_q <= grant_q;
            if (xfer_acc) begin
                bus.m_tdata <= bus.s_tdata[8*grant_q +: 8];
                bus.m_tlast <= s_last || at_max;
                bus.m_tid <= grant_q;
            end
            bus.m_tvalid <= xfer_acc || (bus.m_tvalid && !bus.m_tready);
            pkt_count <= pkt_count + 32'(xfer_acc && (s_last || at_max));
            err_len <= err_len || (xfer_acc && !s_last && at_max);
        end
    end
endmodule

// File: tb/tb_bcrypt_axis8_out_arbiter.sv
// tb_bcrypt_axis8_out_arbiter: directed scenarios plus randomized traffic, every cycle checked
// against a byte-level model of the round-robin merge.
module tb_bcrypt_axis8_out_arbiter;
    localparam int N = 4;
    localparam int SW = 2;
    localparam int MAXB = 8;
    logic CLK = 1'b0;
    logic RSTN = 1'b0;
    logic enable = 1'b0;
    logic busy, err_len;
    logic [31:0] pkt_count;
    bcrypt_axis8_out_arbiter_if #(.NUM_SRC(N), .SRC_W(SW)) bus ();
    bcrypt_axis8_out_arbiter #(.NUM_SRC(N), .MAX_PKT_BYTES(MAXB)) dut (
        .CLK(CLK), .RSTN(RSTN), .bus(bus), .enable(enable),
        .busy(busy), .err_len(err_len), .pkt_count(pkt_count)
    );
    always #5 CLK = ~CLK;
    int tests = 0;
    int fails = 0;
    task automatic chk(string name, longint act, longint exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask
    // Source byte queues: {last, data}; output log entries: tid*512 + last*256 + data
    logic [8:0] srcq [N][$];
    int log_q [$];
    int gap = 100;
    int rdy_mode = 0;
    int pidx = 0;
    logic [3:0] pat = 4'b1001;
    logic [N-1:0] took;
    always @(posedge CLK) begin
        for (int i = 0; i < N; i++) begin
            took[i] = bus.s_tvalid[i] && bus.s_tready[i] && srcq[i].size() > 0;
            if (took[i]) void'(srcq[i].pop_front());
        end
        #1;
        for (int i = 0; i < N; i++) begin
            bus.s_tvalid[i] = srcq[i].size() > 0 &&
                ((bus.s_tvalid[i] && !took[i]) || $urandom_range(99) < gap);
            bus.s_tdata[8*i +: 8] = srcq[i].size() > 0 ? srcq[i][0][7:0] : 8'h00;
            bus.s_tlast[i] = srcq[i].size() > 0 ? srcq[i][0][8] : 1'b0;
        end
        bus.m_tready = rdy_mode == 0 ? 1'b1 : rdy_mode == 1 ? pat[pidx % 4] : ($urandom_range(2) != 0);
        pidx++;
    end
    // Model: owner is the source holding the output (-1 when free), dropping marks an over-long tail
    int owner = -1, cnt = 0, prev = N - 1, pc = 0, oi = 0;
    bit dropping = 0, ov = 0, ol = 0, er = 0, m_take = 0, m_lst = 0;
    logic [7:0] od = 8'h00;
    function automatic logic [N-1:0] exp_rdy();
        if (owner < 0) return '0;
        return (dropping || !ov || bus.m_tready) ? (N'(1) << owner) : '0;
    endfunction
    always @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            owner = -1; cnt = 0; prev = N - 1; pc = 0; oi = 0;
            dropping = 0; ov = 0; ol = 0; er = 0; od = 8'h00;
        end else begin
            m_take = owner >= 0 && bus.s_tvalid[owner] && exp_rdy() != 0;
            m_lst = owner >= 0 && bus.s_tlast[owner];
            if (owner < 0) begin
                if (ov && bus.m_tready) ov = 0;
                if (enable)
                    for (int k = 1; k <= N; k++)
                        if (owner < 0 && bus.s_tvalid[(prev + k) % N]) owner = (prev + k) % N;
            end else if (dropping) begin
                if (ov && bus.m_tready) ov = 0;
                if (m_take && m_lst) begin prev = owner; owner = -1; dropping = 0; end
            end else if (m_take) begin
                cnt++;
                ov = 1; od = bus.s_tdata[8*owner +: 8]; oi = owner; ol = m_lst || cnt == MAXB;
                if (ol) pc++;
                if (m_lst) begin prev = owner; owner = -1; cnt = 0; end
                else if (cnt == MAXB) begin er = 1; dropping = 1; cnt = 0; end
            end else if (ov && bus.m_tready) ov = 0;
        end
    end
    always @(negedge CLK) if (RSTN) begin
        chk("m_tvalid", bus.m_tvalid, ov);
        if (ov) begin
            chk("m_tdata", bus.m_tdata, od);
            chk("m_tlast", bus.m_tlast, ol);
            chk("m_tid", bus.m_tid, oi);
        end
        chk("s_tready", bus.s_tready, exp_rdy());
        chk("busy", busy, owner >= 0 || ov);
        chk("err_len", err_len, er);
        chk("pkt_count", pkt_count, pc);
        if (bus.m_tvalid && bus.m_tready) log_q.push_back(bus.m_tid * 512 + bus.m_tlast * 256 + bus.m_tdata);
    end
    task automatic push(int s, int n, int base, int step);
        for (int k = 0; k < n; k++) srcq[s].push_back({k == n - 1, 8'(base + k * step)});
    endtask
    task automatic assert_reset();
        @(posedge CLK);
        #2 RSTN = 1'b0;
        for (int i = 0; i < N; i++) srcq[i].delete();
        log_q.delete();
    endtask
    task automatic do_reset();
        assert_reset();
        repeat (2) @(negedge CLK);
        RSTN = 1'b1;
    endtask
    task automatic wait_idle(int maxc);
        int k;
        for (k = 0; k < maxc; k++) begin
            @(negedge CLK);
            if (!busy && bus.s_tvalid == 0 && srcq[0].size() + srcq[1].size() + srcq[2].size() + srcq[3].size() == 0) break;
        end
        chk("idle_timeout", k < maxc, 1);
    endtask
    initial begin
        int t;
        do_reset();
        enable = 1'b1;
        // single 3-byte packet from source 0
        push(0, 3, 8'h11, 8'h11);
        for (t = 0; t < 20 && !bus.s_tvalid[0]; t++) @(negedge CLK);
        t = 0;
        while (!bus.m_tvalid && t < 10) begin @(negedge CLK); t++; end
        chk("latency", t, 2);
        wait_idle(50);
        chk("t1_len", log_q.size(), 3);
        chk("t1_b0", log_q[0], 'h011);
        chk("t1_b1", log_q[1], 'h022);
        chk("t1_b2", log_q[2], 'h133);
        chk("t1_pkts", pkt_count, 1);
        // four pending sources, then a second round from 0 and 2
        do_reset();
        enable = 1'b0;
        for (int s = 0; s < N; s++) push(s, 2, 8'h40 + 16 * s, 1);
        repeat (3) @(negedge CLK);
        enable = 1'b1;
        wait_idle(100);
        chk("t2_len", log_q.size(), 8);
        for (int k = 0; k < 8; k++) chk("t2_order", log_q[k] >> 9, k / 2);
        log_q.delete();
        push(0, 2, 8'h01, 1);
        push(2, 2, 8'h21, 1);
        wait_idle(100);
        chk("t2b_len", log_q.size(), 4);
        for (int k = 0; k < 4; k++) chk("t2b_order", log_q[k] >> 9, (k / 2) * 2);
        // back-pressure on a 4-byte packet from source 1
        log_q.delete();
        rdy_mode = 1;
        pidx = 0;
        push(1, 4, 8'hA0, 1);
        wait_idle(100);
        rdy_mode = 0;
        chk("t3_len", log_q.size(), 4);
        for (int k = 0; k < 4; k++) chk("t3_byte", log_q[k], 512 + (k == 3 ? 256 : 0) + 'hA0 + k);
        // over-long packet: 12 bytes against an 8-byte limit
        do_reset();
        push(2, 12, 8'h80, 1);
        wait_idle(100);
        chk("t4_len", log_q.size(), 8);
        chk("t4_b6", log_q[6], 2 * 512 + 'h86);
        chk("t4_b7", log_q[7], 2 * 512 + 256 + 'h87);
        chk("t4_err", err_len, 1);
        chk("t4_pkts", pkt_count, 1);
        log_q.delete();
        push(0, 2, 8'h05, 1);
        wait_idle(100);
        chk("t4b_len", log_q.size(), 2);
        chk("t4b_b1", log_q[1], 256 + 'h06);
        chk("t4b_err", err_len, 1);
        chk("t4b_pkts", pkt_count, 2);
        // enable dropped while source 3 is mid-packet and source 0 waits
        do_reset();
        push(3, 4, 8'h30, 1);
        for (t = 0; t < 50 && log_q.size() == 0; t++) @(negedge CLK);
        chk("t5_start", log_q.size() > 0, 1);
        enable = 1'b0;
        push(0, 2, 8'h60, 1);
        repeat (20) @(negedge CLK);
        chk("t5_len", log_q.size(), 4);
        chk("t5_tid", log_q[3] >> 9, 3);
        chk("t5_pend", srcq[0].size(), 2);
        chk("t5_busy", busy, 0);
        enable = 1'b1;
        wait_idle(100);
        chk("t5b_len", log_q.size(), 6);
        chk("t5b_b0", log_q[4], 'h060);
        // reset in the middle of a packet
        push(1, 6, 8'hC0, 1);
        for (t = 0; t < 50 && !bus.m_tvalid; t++) @(negedge CLK);
        assert_reset();
        #1;
        chk("t6_mvalid", bus.m_tvalid, 0);
        chk("t6_sready", bus.s_tready, 0);
        chk("t6_pkts", pkt_count, 0);
        repeat (2) @(negedge CLK);
        RSTN = 1'b1;
        push(1, 2, 8'hD0, 1);
        push(0, 2, 8'hE0, 1);
        wait_idle(100);
        chk("t6_len", log_q.size(), 4);
        chk("t6_first", log_q[0] >> 9, 0);
        // randomized traffic, back-pressure and enable toggling
        do_reset();
        rdy_mode = 2;
        gap = 60;
        for (int c = 0; c < 4000; c++) begin
            @(negedge CLK);
            for (int s = 0; s < N; s++)
                if (srcq[s].size() < 3 && $urandom_range(15) == 0)
                    push(s, $urandom_range(12, 1), $urandom_range(255), 1);
            if ($urandom_range(31) == 0) enable = $urandom_range(3) != 0;
        end
        enable = 1'b1;
        wait_idle(3000);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/bcrypt_axis8_out_arbiter.md
Name: bcrypt_axis8_out_arbiter

Overview:
- Merges the 8-bit AXI4-Stream result outputs of NUM_SRC bcrypt wrapper instances onto one AXIS8 host stream.
- Arbitration is packet-atomic round-robin, so a granted source keeps the output until its TLAST.
- Enforces a maximum packet length and tags each output byte with its source index.
- Sits between the bcrypt wrapper instances and the LiteX host DMA/UART sink.

Parameters:
- NUM_SRC, 4, number of AXIS8 sources (2..16).
- MAX_PKT_BYTES, 1024, maximum bytes per packet before forced termination.
- SRC_W, $clog2(NUM_SRC), width of the source index (derived).

Ports:
- CLK  in  1  clock.
- RSTN  in  1  reset; asynchronous, active-low.
- s_tdata  in  NUM_SRC*8  per-source data; source i occupies bits [8i+7:8i].
- s_tvalid  in  NUM_SRC  per-source valid.
- s_tready  out  NUM_SRC  per-source ready.
- s_tlast  in  NUM_SRC  per-source end of packet.
- m_tdata  out  8  merged output data.
- m_tvalid  out  1  merged output valid.
- m_tready  in  1  merged output ready.
- m_tlast  out  1  merged output end of packet.
- m_tid  out  SRC_W  source index of the current output byte.
- enable  in  1  permits new grants; has no effect on a packet already in progress.
- busy  out  1  high in XFER or DRAIN, or while the output register holds data.
- err_len  out  1  sticky flag: a packet exceeded MAX_PKT_BYTES.
- pkt_count  out  32  number of packets completed on the output; wraps at 2^32.

Behaviour:
- Reset values:
  - all outputs 0; s_tready all 0.
  - state = IDLE; last_grant = NUM_SRC-1, so source 0 has first priority; byte counter = 0.
- Output stage: a single register {m_tdata, m_tlast, m_tid} plus m_tvalid.
  - It loads when a source byte is accepted.
  - m_tvalid clears on (m_tvalid & m_tready) when no new byte loads in the same cycle.
  - Sustained throughput is 1 byte/cycle; latency from source accept to m_tvalid is 1 cycle.
- State IDLE:
  - s_tready = 0.
  - If enable and |s_tvalid, grant the first i with s_tvalid[i], searching from (last_grant+1) mod NUM_SRC upward with wrap.
  - Register the grant and go to XFER next cycle; the grant decision costs 1 cycle.
- State XFER:
  - s_tready[g] = (~m_tvalid | m_tready); all other s_tready = 0.
  - Accept = s_tvalid[g] & s_tready[g].
  - On accept: the byte counter increments; m_tid = g.
  - Accept with s_tlast[g]:
    - m_tlast = 1, pkt_count += 1, last_grant = g, byte counter cleared.
    - Go to IDLE.
  - Accept where the counter reaches MAX_PKT_BYTES without s_tlast:
    - Emit that byte with m_tlast forced to 1; set err_len; pkt_count += 1.
    - Go to DRAIN.
- State DRAIN:
  - s_tready[g] = 1; accepted bytes are discarded and never reach the output.
  - On an accepted byte with s_tlast: last_grant = g, counter cleared, go to IDLE.
- Additional rules:
  - enable deasserted mid-packet: the current packet finishes normally; no new grant is made until enable returns.
  - Source valid dropping mid-packet: XFER holds the grant indefinitely and output bubbles are allowed.
  - A byte arriving exactly at MAX_PKT_BYTES with s_tlast is a normal end: no error, no DRAIN.
  - A single-source request always wins regardless of last_grant.
  - Non-granted sources never see s_tready = 1.
- Reset mid-operation: everything returns immediately to the reset values. A partial output packet is lost; m_tvalid drops with no TLAST.
- err_len clears only on reset.

Test Plan:
- Single source 0 sends a 3-byte packet (0x11, 0x22, 0x33 with last) with m_tready = 1 → m_tvalid rises 2 cycles after the first s_tvalid, one byte per cycle, m_tlast on 0x33, m_tid = 0, pkt_count = 1.
- Sources 0..3 each hold a 2-byte packet pending simultaneously → output order 0, 1, 2, 3. A second round from sources 0 and 2 → order 0, 2. Packets never interleave.
- Back-pressure: m_tready toggles 1,0,0,1 during source 1's 4-byte packet → no byte lost or duplicated; s_tready[1] low whenever m_tvalid & ~m_tready.
- MAX_PKT_BYTES = 8, source 2 sends 12 bytes with last on byte 12 → 8 bytes output with m_tlast on byte 8; err_len = 1; bytes 9–12 drained; pkt_count = 1; next grant proceeds normally.
- enable drops 1 cycle into source 3's packet while source 0 is pending → source 3's packet completes; source 0 is not granted until enable = 1 again.
- RSTN asserted mid-packet → m_tvalid = 0, s_tready = 0, and pkt_count = 0 in the same cycle. After release, source 0 has priority again.
